// File: rtl/xbar_w_route_fifo_pkg.sv
// Shared types and constants for the crossbar W-channel routing stage.
// The route entry carries the AW length only when XBAR_W_LEN_CHECK_EN is defined.
package xbar_route_pkg;

  // Width needed to hold an index 0..n-1 (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NoSlv     = 4;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 8;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SelWidth  = idx_width(NoSlv + 1);

  typedef logic [SelWidth-1:0] sel_t;

  // The index one past the last real slave marks a decode error.
  localparam sel_t DECERR_SEL = sel_t'(NoSlv);

  typedef struct packed {
    sel_t       sel;
`ifdef XBAR_W_LEN_CHECK_EN
    logic [7:0] len;
`endif
  } route_entry_t;

  // Anything beyond the error code is folded onto it.
  function automatic sel_t sanitize_sel(input sel_t s);
    return (s > DECERR_SEL) ? DECERR_SEL : s;
  endfunction

endpackage

// File: rtl/xbar_w_route_fifo_if.sv
// AW routing handshake plus upstream and per-slave W channel bundle.
// slave modport: the routing stage; master modport: the upstream driver.
interface xbar_w_route_fifo_if;
  import xbar_route_pkg::*;

  logic                 aw_valid_i;
  logic                 aw_ready_o;
  sel_t                 aw_sel_i;
  logic [7:0]           aw_len_i;

  logic                 w_valid_i;
  logic                 w_ready_o;
  logic [DataWidth-1:0] w_data_i;
  logic [StrbWidth-1:0] w_strb_i;
  logic                 w_last_i;
  logic [UserWidth-1:0] w_user_i;

  logic [NoSlv-1:0]     mst_w_valid_o;
  logic [NoSlv-1:0]     mst_w_ready_i;
  logic [DataWidth-1:0] mst_w_data_o;
  logic [StrbWidth-1:0] mst_w_strb_o;
  logic                 mst_w_last_o;
  logic [UserWidth-1:0] mst_w_user_o;

  modport slave (
    input  aw_valid_i, aw_sel_i, aw_len_i,
    output aw_ready_o,
    input  w_valid_i, w_data_i, w_strb_i, w_last_i, w_user_i,
    output w_ready_o,
    output mst_w_valid_o, mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_user_o,
    input  mst_w_ready_i
  );

  modport master (
    output aw_valid_i, aw_sel_i, aw_len_i,
    input  aw_ready_o,
    output w_valid_i, w_data_i, w_strb_i, w_last_i, w_user_i,
    input  w_ready_o,
    input  mst_w_valid_o, mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_user_o,
    output mst_w_ready_i
  );

endinterface

// File: rtl/xbar_w_route_fifo_idx_fifo.sv
// Small synchronous FIFO of routing entries. No fall-through: a pushed entry
// becomes visible at head_o on the following cycle at the earliest.
// Depth must be a power of two so the pointers wrap naturally.
module xbar_idx_fifo
  import xbar_route_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  route_entry_t data_i,
  input  logic         pop_i,
  output route_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = idx_width(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  route_entry_t mem_q [Depth];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  cnt_t         count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == cnt_t'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; cleared asynchronously so a reset discards all entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/xbar_w_route_fifo.sv
// W-channel steering stage behind the crossbar AW decoder. Each accepted AW
// records its slave index; W beats go to the head entry's slave until WLAST.
// Decode-error bursts are sunk locally.
// Optional: XBAR_W_LEN_CHECK_EN adds an AWLEN vs. beat-count checker
// (w_len_err_o); routing is identical either way.
module xbar_w_route_fifo #(
  parameter int unsigned FifoDepth = xbar_route_pkg::FifoDepth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  xbar_w_route_fifo_if.slave  bus,
  output logic                decerr_w_done_o,
  output logic                empty_o
`ifdef XBAR_W_LEN_CHECK_EN
  ,
  output logic                w_len_err_o
`endif
);
  import xbar_route_pkg::*;

  route_entry_t     push_entry;
  route_entry_t     head;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             w_ready;
  logic             head_is_err;
  logic [NoSlv-1:0] mst_valid;

  // aw_ready depends only on registered occupancy, never on the W side.
  assign bus.aw_ready_o = !fifo_full;
  assign push           = bus.aw_valid_i && !fifo_full;

  // Build the entry to store; out-of-range indices become the error code.
  always_comb begin
    push_entry     = '0;
    push_entry.sel = sanitize_sel(bus.aw_sel_i);
`ifdef XBAR_W_LEN_CHECK_EN
    push_entry.len = bus.aw_len_i;
`endif
  end

  xbar_idx_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Steer valid to the head slave and return its ready; sink error bursts.
  always_comb begin
    mst_valid   = '0;
    w_ready     = 1'b0;
    head_is_err = 1'b0;
    if (!fifo_empty) begin
      if (head.sel == DECERR_SEL) begin
        head_is_err = 1'b1;
        w_ready     = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NoSlv; i++) begin
          if (head.sel == sel_t'(i)) begin
            mst_valid[i] = bus.w_valid_i;
            w_ready      = bus.mst_w_ready_i[i];
          end
        end
      end
    end
  end

  assign pop             = bus.w_valid_i && w_ready && bus.w_last_i;
  assign decerr_w_done_o = pop && head_is_err;
  assign empty_o         = fifo_empty;

  assign bus.w_ready_o     = w_ready;
  assign bus.mst_w_valid_o = mst_valid;
  assign bus.mst_w_data_o  = bus.w_data_i;
  assign bus.mst_w_strb_o  = bus.w_strb_i;
  assign bus.mst_w_last_o  = bus.w_last_i;
  assign bus.mst_w_user_o  = bus.w_user_i;

`ifdef XBAR_W_LEN_CHECK_EN
  // beat_cnt_q is the zero-based index of the next beat in the current burst,
  // so a well-formed burst carries WLAST exactly when the index equals AWLEN.
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       len_err_q, len_err_d;
  logic       w_hs;

  assign w_hs = bus.w_valid_i && w_ready;

  // Beat index tracking and error detection per W handshake.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    len_err_d  = 1'b0;
    if (w_hs) begin
      if (bus.w_last_i) begin
        len_err_d  = (beat_cnt_q != head.len);
        beat_cnt_d = '0;
      end else begin
        len_err_d  = (beat_cnt_q == head.len);
        beat_cnt_d = beat_cnt_q + 8'd1;
      end
    end
  end

  // Register the counter and the one-cycle error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign w_len_err_o = len_err_q;
`else
  logic unused_len;
  assign unused_len = ^bus.aw_len_i;
`endif

endmodule

// File: tb/tb_xbar_w_route_fifo.sv
// Bench for xbar_w_route_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference of the routing rules.
module tb_xbar_w_route_fifo;
  import xbar_route_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic decerr_w_done, empty;
`ifdef XBAR_W_LEN_CHECK_EN
  logic w_len_err;
`endif

  xbar_w_route_fifo_if bus();

  xbar_w_route_fifo #(.FifoDepth(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .decerr_w_done_o (decerr_w_done),
    .empty_o         (empty)
`ifdef XBAR_W_LEN_CHECK_EN
    ,
    .w_len_err_o     (w_len_err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: outstanding AW slave indices in acceptance order (4 = error).
  int               q[$];
  logic             exp_aw_ready, exp_w_ready, exp_decerr, exp_empty;
  logic [NoSlv-1:0] exp_mv;

  task automatic model_eval();
    int head;
    exp_aw_ready = (q.size() < 4);
    exp_empty    = (q.size() == 0);
    exp_mv       = '0;
    exp_w_ready  = 1'b0;
    exp_decerr   = 1'b0;
    if (q.size() > 0) begin
      head = q[0];
      if (head == 4) begin
        exp_w_ready = 1'b1;
        exp_decerr  = bus.w_valid_i && bus.w_last_i;
      end else begin
        exp_mv[head] = bus.w_valid_i;
        exp_w_ready  = bus.mst_w_ready_i[head];
      end
    end
  endtask

  // Advance the reference with the current inputs, then one clock.
  task automatic tick();
    bit pop, push;
    int sel;
    model_eval();
    pop  = (q.size() > 0) && bus.w_valid_i && exp_w_ready && bus.w_last_i;
    push = bus.aw_valid_i && exp_aw_ready;
    sel  = int'(bus.aw_sel_i);
    if (pop) void'(q.pop_front());
    if (push) q.push_back((sel > 4) ? 4 : sel);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic idle();
    bus.aw_valid_i    = 1'b0;
    bus.aw_sel_i      = '0;
    bus.aw_len_i      = '0;
    bus.w_valid_i     = 1'b0;
    bus.w_last_i      = 1'b0;
    bus.w_data_i      = '0;
    bus.w_strb_i      = '0;
    bus.w_user_i      = '0;
    bus.mst_w_ready_i = '1;
  endtask

  task automatic test_reset();
    idle();
    bus.w_valid_i = 1'b1;
    rst = 1'b1;
    q.delete();
    #1;
    n_tests++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready: got %b, expected 1", bus.aw_ready_o); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, expected 1", empty); end
    n_tests++; if (bus.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready: got %b, expected 0", bus.w_ready_o); end
    n_tests++; if (bus.mst_w_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_mst_valid: got %b, expected 0000", bus.mst_w_valid_o); end
    n_tests++; if (decerr_w_done !== 1'b0) begin n_fail++; $display("FAIL reset_decerr: got %b, expected 0", decerr_w_done); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int errs = 0;
    idle();
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd2; bus.aw_len_i = 8'd3;
    bus.w_valid_i  = 1'b1; bus.w_data_i = {$urandom, $urandom};
    settle();
    n_tests++; if (bus.w_ready_o !== 1'b0 || bus.mst_w_valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_no_fallthrough: got ready=%b valid=%b, expected 0/0000", bus.w_ready_o, bus.mst_w_valid_o); end
    tick();
    bus.aw_valid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.w_data_i = {$urandom, $urandom};
      bus.w_last_i = (b == 3);
      settle();
`ifdef XBAR_W_LEN_CHECK_EN
      errs += int'(w_len_err);
`endif
      n_tests++; if (bus.mst_w_valid_o !== 4'b0100 || bus.w_ready_o !== 1'b1 || bus.mst_w_data_o !== bus.w_data_i || bus.mst_w_last_o !== bus.w_last_i) begin
        n_fail++; $display("FAIL single_beat%0d: got valid=%b ready=%b data=%h last=%b, expected 0100/1/%h/%b", b, bus.mst_w_valid_o, bus.w_ready_o, bus.mst_w_data_o, bus.mst_w_last_o, bus.w_data_i, bus.w_last_i);
      end
      tick();
    end
    idle();
    settle();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b, expected 1", empty); end
`ifdef XBAR_W_LEN_CHECK_EN
    errs += int'(w_len_err);
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL single_len_ok: got %0d pulses, expected 0", errs); end
`endif
  endtask

  task automatic test_ordering();
    int sels[3]  = '{0, 3, 1};
    int beats[3] = '{1, 2, 1};
    int want[4]  = '{0, 3, 3, 1};
    int obs[$];
    bit ok;
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.aw_valid_i = 1'b1; bus.aw_sel_i = sel_t'(sels[i]); bus.aw_len_i = 8'(beats[i] - 1);
      settle();
      n_tests++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL order_aw_ready%0d: got %b, expected 1", i, bus.aw_ready_o); end
      tick();
    end
    bus.aw_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < beats[i]; b++) begin
        bus.w_valid_i = 1'b1; bus.w_last_i = (b == beats[i] - 1);
        settle();
        for (int s = 0; s < 4; s++) if (bus.mst_w_valid_o[s] === 1'b1) obs.push_back(s);
        tick();
      end
    end
    idle();
    ok = (obs.size() == 4);
    if (ok) for (int k = 0; k < 4; k++) if (obs[k] != want[k]) ok = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL order_sequence: got %p, expected %p", obs, want); end
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.aw_valid_i = 1'b1; bus.aw_sel_i = sel_t'(i);
      settle();
      n_tests++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %b, expected 1", i, bus.aw_ready_o); end
      tick();
    end
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd2;
    settle();
    n_tests++; if (bus.aw_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_aw_ready: got %b, expected 0", bus.aw_ready_o); end
    tick();
    bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
    settle();
    n_tests++; if (bus.aw_ready_o !== 1'b0 || bus.w_ready_o !== 1'b1 || bus.mst_w_valid_o !== 4'b0001) begin
      n_fail++; $display("FAIL full_pop_same_cycle: got awready=%b wready=%b valid=%b, expected 0/1/0001", bus.aw_ready_o, bus.w_ready_o, bus.mst_w_valid_o);
    end
    tick();
    bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
    settle();
    n_tests++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got %b, expected 1", bus.aw_ready_o); end
    tick();
    bus.aw_valid_i = 1'b0;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
      settle();
      n_tests++; if (bus.mst_w_valid_o !== exp_mv) begin n_fail++; $display("FAIL full_drain%0d: got %b, expected %b", k, bus.mst_w_valid_o, exp_mv); end
      tick();
    end
    idle();
    settle();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty: got %b, expected 1", empty); end
  endtask

  task automatic test_decerr();
    idle();
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd4; bus.aw_len_i = 8'd1;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.mst_w_ready_i = '0;
    for (int b = 0; b < 2; b++) begin
      bus.w_valid_i = 1'b1; bus.w_last_i = (b == 1);
      settle();
      n_tests++; if (bus.w_ready_o !== 1'b1 || bus.mst_w_valid_o !== 4'b0000 || decerr_w_done !== (b == 1)) begin
        n_fail++; $display("FAIL decerr_beat%0d: got ready=%b valid=%b done=%b, expected 1/0000/%0d", b, bus.w_ready_o, bus.mst_w_valid_o, decerr_w_done, b);
      end
      tick();
    end
    idle();
    settle();
    n_tests++; if (decerr_w_done !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL decerr_after: got done=%b empty=%b, expected 0/1", decerr_w_done, empty); end
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd7;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
    settle();
    n_tests++; if (decerr_w_done !== 1'b1 || bus.mst_w_valid_o !== 4'b0000) begin n_fail++; $display("FAIL decerr_illegal_sel: got done=%b valid=%b, expected 1/0000", decerr_w_done, bus.mst_w_valid_o); end
    tick();
    idle();
  endtask

  task automatic test_backpressure();
    logic [63:0] d1;
    idle();
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd1; bus.aw_len_i = 8'd3;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i = 1'b1; bus.w_data_i = {$urandom, $urandom};
    settle();
    n_tests++; if (bus.w_ready_o !== 1'b1 || bus.mst_w_valid_o !== 4'b0010) begin n_fail++; $display("FAIL bp_first: got ready=%b valid=%b, expected 1/0010", bus.w_ready_o, bus.mst_w_valid_o); end
    tick();
    d1 = {$urandom, $urandom};
    bus.w_data_i = d1;
    bus.mst_w_ready_i = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_tests++; if (bus.w_ready_o !== 1'b0 || bus.mst_w_valid_o !== 4'b0010 || bus.mst_w_data_o !== d1) begin
        n_fail++; $display("FAIL bp_stall%0d: got ready=%b valid=%b data=%h, expected 0/0010/%h", c, bus.w_ready_o, bus.mst_w_valid_o, bus.mst_w_data_o, d1);
      end
      tick();
    end
    bus.mst_w_ready_i = '1;
    for (int b = 1; b < 4; b++) begin
      bus.w_last_i = (b == 3);
      settle();
      n_tests++; if (bus.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_resume%0d: got %b, expected 1", b, bus.w_ready_o); end
      tick();
      bus.w_data_i = {$urandom, $urandom};
    end
    idle();
    settle();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty: got %b, expected 1", empty); end
  endtask

  task automatic test_reset_mid_burst();
    idle();
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd2; bus.aw_len_i = 8'd3;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i = 1'b1;
    settle();
    n_tests++; if (bus.mst_w_valid_o !== 4'b0100) begin n_fail++; $display("FAIL rstmid_beat1: got %b, expected 0100", bus.mst_w_valid_o); end
    tick();
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    n_tests++; if (empty !== 1'b1 || bus.aw_ready_o !== 1'b1 || bus.w_ready_o !== 1'b0 || bus.mst_w_valid_o !== 4'b0000 || decerr_w_done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got empty=%b awready=%b wready=%b valid=%b done=%b, expected 1/1/0/0000/0", empty, bus.aw_ready_o, bus.w_ready_o, bus.mst_w_valid_o, decerr_w_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_tests++; if (bus.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall%0d: got %b, expected 0", c, bus.w_ready_o); end
      tick();
    end
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd0; bus.aw_len_i = 8'd2;
    settle();
    n_tests++; if (bus.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_newaw_stall: got %b, expected 0", bus.w_ready_o); end
    tick();
    bus.aw_valid_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.w_last_i = (b == 2);
      settle();
      n_tests++; if (bus.mst_w_valid_o !== 4'b0001 || bus.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_route%0d: got valid=%b ready=%b, expected 0001/1", b, bus.mst_w_valid_o, bus.w_ready_o); end
      tick();
    end
    idle();
    settle();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b, expected 1", empty); end
  endtask

`ifdef XBAR_W_LEN_CHECK_EN
  task automatic test_len_err();
    int pulses = 0;
    idle();
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd0; bus.aw_len_i = 8'd1;
    tick();
    bus.aw_valid_i = 1'b0;
    bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
    settle();
    pulses += int'(w_len_err);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      pulses += int'(w_len_err);
      tick();
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL len_early_last: got %0d pulses, expected 1", pulses); end
    pulses = 0;
    bus.aw_valid_i = 1'b1; bus.aw_sel_i = 3'd3; bus.aw_len_i = 8'd0;
    tick();
    bus.aw_valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.w_valid_i = 1'b1; bus.w_last_i = (b == 1);
      settle();
      pulses += int'(w_len_err);
      tick();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      settle();
      pulses += int'(w_len_err);
      tick();
    end
    n_tests++; if (pulses != 2) begin n_fail++; $display("FAIL len_missing_last: got %0d pulses, expected 2", pulses); end
  endtask
`endif

  task automatic test_random();
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.aw_valid_i    = ($urandom_range(0, 2) == 0);
      bus.aw_sel_i      = sel_t'($urandom_range(0, 7));
      bus.aw_len_i      = 8'($urandom);
      bus.w_valid_i     = $urandom_range(0, 1) != 0;
      bus.w_last_i      = ($urandom_range(0, 2) == 0);
      bus.w_data_i      = {$urandom, $urandom};
      bus.w_strb_i      = 8'($urandom);
      bus.w_user_i      = 8'($urandom);
      bus.mst_w_ready_i = 4'($urandom);
      settle();
      n_tests++; if ({bus.aw_ready_o, bus.w_ready_o, empty, decerr_w_done} !== {exp_aw_ready, exp_w_ready, exp_empty, exp_decerr}) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: got awr/wr/empty/done=%b%b%b%b, expected %b%b%b%b", cyc, bus.aw_ready_o, bus.w_ready_o, empty, decerr_w_done, exp_aw_ready, exp_w_ready, exp_empty, exp_decerr);
      end
      n_tests++; if (bus.mst_w_valid_o !== exp_mv) begin n_fail++; $display("FAIL rand_valid@%0d: got %b, expected %b", cyc, bus.mst_w_valid_o, exp_mv); end
      n_tests++; if ({bus.mst_w_data_o, bus.mst_w_strb_o, bus.mst_w_last_o, bus.mst_w_user_o} !== {bus.w_data_i, bus.w_strb_i, bus.w_last_i, bus.w_user_i}) begin
        n_fail++; $display("FAIL rand_payload@%0d: got %h/%h/%b/%h, expected %h/%h/%b/%h", cyc, bus.mst_w_data_o, bus.mst_w_strb_o, bus.mst_w_last_o, bus.mst_w_user_o, bus.w_data_i, bus.w_strb_i, bus.w_last_i, bus.w_user_i);
      end
      tick();
    end
    idle();
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
      tick();
    end
    idle();
    settle();
    n_tests++; if (empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got empty=%b, model size %0d, expected 1/0", empty, q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single_burst();
    test_ordering();
    test_full();
    test_decerr();
    test_backpressure();
    test_reset_mid_burst();
`ifdef XBAR_W_LEN_CHECK_EN
    test_len_err();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
